branch_sequencer: RTL
=====================

Name: branch_sequencer

Overview:
- Moore-style control FSM that steps the datapath through fetch and execution of one conditional-branch instruction (T0..T6).
- Asserts the datapath strobes each step needs, pulses con_in so the CON FF logic evaluates the IR condition against the bus, and gates pc_in with the registered con_ff result.
- Sits between the top-level control unit, which issues start/done, and the datapath register enables.

Parameters:
- BR_OPCODE, 5'b10010, IR[31:27] value identifying a conditional branch.
- MEM_TIMEOUT, 15, maximum cycles spent in T1 waiting for mem_ready before abort; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- start  input  1  begin one branch instruction; sampled only in IDLE.
- mem_ready  input  1  memory read data valid on Mdatain.
- ir_opcode  input  5  IR[31:27], valid from T3 onward.
- con_ff  input  1  registered CON FF output.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- taken  output  1  registered: branch taken on the last completed instruction.
- error  output  1  sticky: illegal opcode or memory timeout; cleared by the next accepted start.
- pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add  output  1 each  datapath strobes.

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE; timeout counter=0; taken=0; error=0; done=0; all strobes 0.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE.
- Strobes are decoded from the current state only, except pc_in in T6. Exactly these are high; all others are 0:
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: zlow_out, pc_in, read, mdr_in.
  - T2: mdr_out, ir_in.
  - T3: gra, r_out, con_in.
  - T4: pc_out, y_in.
  - T5: c_out, alu_add, z_in.
  - T6: zlow_out, pc_in=con_ff.
- The T1 pc_in strobe applies only on the first T1 cycle (the entry cycle). A flag registered on T1 entry suppresses it on later wait cycles.
- Transitions:
  - IDLE -> T0 when start=1. On this edge error is cleared.
  - T0 -> T1 unconditionally; the timeout counter loads 0.
  - T1 -> T2 when mem_ready=1 in that cycle.
  - Otherwise T1 increments the counter and stays. When the counter reaches MEM_TIMEOUT with mem_ready=0: error<=1, -> DONE, skipping T2..T6.
  - T2 -> T3.
  - T3 -> T4 if ir_opcode==BR_OPCODE. Otherwise error<=1, -> DONE; con_in has already pulsed but pc is untouched.
  - T4 -> T5 -> T6.
  - T6 -> DONE; taken<=con_ff.
  - DONE -> IDLE; done=1 during DONE.
- Nominal latency with mem_ready already high: start sampled at edge 0; done high in cycle 8 (IDLE,T0..T6,DONE = 9 states).
- start outside IDLE is ignored; no queuing.
- mem_ready outside T1 is ignored.
- Reset mid-sequence returns to IDLE immediately and drops all strobes in the same cycle.
- taken is unchanged on error paths.

Optional Feature:
- Macro BRANCH_SEQ_STATS_EN.
- When defined:
  - Adds outputs taken_count[15:0] and branch_count[15:0], reset to 0.
  - branch_count increments on every T6->DONE transition.
  - taken_count increments when con_ff=1 at that transition.
  - Both counters wrap 16'hFFFF->0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then start=1 for one cycle, mem_ready=1, ir_opcode=5'b10010, con_ff=1. Required:
  - Strobe sets match T0..T6 exactly, one cycle each.
  - pc_in=1 in T6.
  - done in cycle 8; taken=1; error=0.
- Same sequence with con_ff=0. Required:
  - pc_in=0 in T6; taken=0; done in cycle 8.
- mem_ready held low 3 cycles in T1, then high. Required:
  - read and mdr_in stay high for 4 cycles; pc_in high only in the first of them.
  - done in cycle 11.
- mem_ready never asserted, MEM_TIMEOUT=15. Required:
  - 15 cycles in T1, then DONE; error=1; ir_in and the T6 pc_in never asserted.
  - Next start clears error.
- ir_opcode=5'b00011. Required:
  - con_in pulses in T3, then DONE; error=1; y_in, c_out and the T6 pc_in never asserted.
- clr_n pulsed low during T4. Required:
  - All strobes 0 and busy=0 asynchronously.
  - With BRANCH_SEQ_STATS_EN, 3 taken + 2 not-taken runs give branch_count=5, taken_count=3.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// Control/strobe bundle between the top-level control unit, the branch sequencer and the datapath.
// Optional statistics counters appear when BRANCH_SEQ_STATS_EN is defined.
interface branch_sequencer_if;
  logic       start;
  logic       mem_ready;
  logic [4:0] ir_opcode;
  logic       con_ff;
  logic       busy;
  logic       done;
  logic       taken;
  logic       error;
  logic       pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in;
  logic       mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add;
`ifdef BRANCH_SEQ_STATS_EN
  logic [15:0] taken_count;
  logic [15:0] branch_count;
`endif

  modport slave (
    input  start, mem_ready, ir_opcode, con_ff,
    output busy, done, taken, error,
    output pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in,
    output mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add
`ifdef BRANCH_SEQ_STATS_EN
    , output taken_count, branch_count
`endif
  );

  modport master (
    output start, mem_ready, ir_opcode, con_ff,
    input  busy, done, taken, error,
    input  pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in,
    input  mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add
`ifdef BRANCH_SEQ_STATS_EN
    , input taken_count, branch_count
`endif
  );
endinterface

// File: rtl/branch_sequencer.sv
// Moore FSM sequencing fetch and execution of one conditional branch (T0..T6).
// Optional taken/branch statistics counters are enabled by BRANCH_SEQ_STATS_EN.
module branch_sequencer #(
  parameter logic [4:0]  BR_OPCODE   = 5'b10010,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               clr_n,
  branch_sequencer_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_DONE = 4'd8
  } state_t;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, z_in, zlow_out, read, mdr_in, mdr_out;
    logic ir_in, gra, r_out, con_in, y_in, c_out, alu_add;
  } strobes_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  strobes_t   r_strb;
  logic [7:0] r_cnt;
  logic       r_pc_in_t1;
  logic       r_t6;
  logic       r_busy;
  logic       r_done;
  logic       r_taken;
  logic       r_error;
  logic       w_abort;

  // pc_in is excluded here: it depends on T1 entry and on con_ff in T6.
  function automatic strobes_t decode(input state_t s);
    strobes_t d;
    d = '0;
    case (s)
      S_T0: begin d.pc_out = 1'b1; d.mar_in = 1'b1; d.inc_pc = 1'b1; d.z_in = 1'b1; end
      S_T1: begin d.zlow_out = 1'b1; d.read = 1'b1; d.mdr_in = 1'b1; end
      S_T2: begin d.mdr_out = 1'b1; d.ir_in = 1'b1; end
      S_T3: begin d.gra = 1'b1; d.r_out = 1'b1; d.con_in = 1'b1; end
      S_T4: begin d.pc_out = 1'b1; d.y_in = 1'b1; end
      S_T5: begin d.c_out = 1'b1; d.alu_add = 1'b1; d.z_in = 1'b1; end
      S_T6: begin d.zlow_out = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_T0;
        else           w_next = S_IDLE;
      end
      S_T0: w_next = S_T1;
      S_T1: begin
        if (bus.mem_ready) begin
          w_next = S_T2;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end else begin
          w_next = S_T1;
        end
      end
      S_T2: w_next = S_T3;
      S_T3: begin
        if (bus.ir_opcode == BR_OPCODE) begin
          w_next = S_T4;
        end else begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end
      end
      S_T4:   w_next = S_T5;
      S_T5:   w_next = S_T6;
      S_T6:   w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= S_IDLE;
      r_strb     <= '0;
      r_cnt      <= 8'd0;
      r_pc_in_t1 <= 1'b0;
      r_t6       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_taken    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_strb     <= decode(w_next);
      r_pc_in_t1 <= (r_state == S_T0);
      r_t6       <= (w_next == S_T6);
      r_busy     <= (w_next != S_IDLE);
      r_done     <= (w_next == S_DONE);

      if (r_state == S_T0)                        r_cnt <= 8'd0;
      else if (r_state == S_T1 && !bus.mem_ready) r_cnt <= r_cnt + 8'd1;
      else                                        r_cnt <= r_cnt;

      if (r_state == S_IDLE && bus.start) r_error <= 1'b0;
      else if (w_abort)                   r_error <= 1'b1;
      else                                r_error <= r_error;

      if (r_state == S_T6) r_taken <= bus.con_ff;
      else                 r_taken <= r_taken;
    end
  end

`ifdef BRANCH_SEQ_STATS_EN
  logic [15:0] r_taken_count;
  logic [15:0] r_branch_count;

  // Completed-branch statistics; both counters wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_taken_count  <= 16'd0;
      r_branch_count <= 16'd0;
    end else if (r_state == S_T6) begin
      r_branch_count <= r_branch_count + 16'd1;
      r_taken_count  <= r_taken_count + {15'd0, bus.con_ff};
    end else begin
      r_taken_count  <= r_taken_count;
      r_branch_count <= r_branch_count;
    end
  end

  assign bus.taken_count  = r_taken_count;
  assign bus.branch_count = r_branch_count;
`endif

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.taken    = r_taken;
  assign bus.error    = r_error;
  assign bus.pc_out   = r_strb.pc_out;
  assign bus.mar_in   = r_strb.mar_in;
  assign bus.inc_pc   = r_strb.inc_pc;
  assign bus.z_in     = r_strb.z_in;
  assign bus.zlow_out = r_strb.zlow_out;
  assign bus.pc_in    = r_pc_in_t1 | (r_t6 & bus.con_ff);
  assign bus.read     = r_strb.read;
  assign bus.mdr_in   = r_strb.mdr_in;
  assign bus.mdr_out  = r_strb.mdr_out;
  assign bus.ir_in    = r_strb.ir_in;
  assign bus.gra      = r_strb.gra;
  assign bus.r_out    = r_strb.r_out;
  assign bus.con_in   = r_strb.con_in;
  assign bus.y_in     = r_strb.y_in;
  assign bus.c_out    = r_strb.c_out;
  assign bus.alu_add  = r_strb.alu_add;
endmodule
